// File: rtl/updown_counter_if.sv
// Control/status bundle for updown_counter.
// With UPDOWN_COUNTER_CAPTURE_EN defined the bundle also carries cap_i/cap_o.
interface updown_counter_if #(
  parameter int unsigned width = 10
);
  logic             clr_i;
  logic             ld_i;
  logic [width-1:0] ld_dat_i;
  logic             en_i;
  logic             dir_i;
  logic             sat_i;
  logic [width-1:0] dat_o;
  logic             tc_o;
  logic             ovf_o;
`ifdef UPDOWN_COUNTER_CAPTURE_EN
  logic             cap_i;
  logic [width-1:0] cap_o;
`endif

  // Master drives the controls and observes the counter outputs.
  modport master (
    output clr_i, ld_i, ld_dat_i, en_i, dir_i, sat_i,
`ifdef UPDOWN_COUNTER_CAPTURE_EN
    output cap_i,
    input  cap_o,
`endif
    input  dat_o, tc_o, ovf_o
  );

  // Slave is the counter itself.
  modport slave (
    input  clr_i, ld_i, ld_dat_i, en_i, dir_i, sat_i,
`ifdef UPDOWN_COUNTER_CAPTURE_EN
    input  cap_i,
    output cap_o,
`endif
    output dat_o, tc_o, ovf_o
  );
endinterface

// File: rtl/updown_counter.sv
// Up/down modulo counter with load, clear, wrap/saturate boundary handling,
// a terminal-count strobe and a sticky overflow flag.
// Optional capture register enabled by UPDOWN_COUNTER_CAPTURE_EN.
module updown_counter #(
  parameter int unsigned width  = 10,
  parameter int unsigned maxval = 1023
) (
  input  logic             clk_i,
  input  logic             rst_i,
  updown_counter_if.slave  bus
);

  // Arithmetic is carried one bit wider so that maxval = 2**width-1 compares
  // and increments cleanly.
  localparam logic [width:0]   MAX_EXT = (width+1)'(maxval);
  localparam logic [width-1:0] MAX_W   = MAX_EXT[width-1:0];

  logic [width-1:0] dat_q, dat_d;
  logic             tc_q,  tc_d;
  logic             ovf_q, ovf_d;

  logic [width:0] dat_ext;
  logic [width:0] ld_ext;
  logic [width:0] inc_ext;
  logic [width:0] dec_ext;

  assign dat_ext = {1'b0, dat_q};
  assign ld_ext  = {1'b0, bus.ld_dat_i};
  assign inc_ext = dat_ext + 1'b1;
  assign dec_ext = dat_ext - 1'b1;

  // Next-state: clear beats load beats count; tc is a one-cycle pulse.
  always_comb begin
    dat_d = dat_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (bus.clr_i) begin
      dat_d = '0;
      ovf_d = 1'b0;
    end else if (bus.ld_i) begin
      dat_d = (ld_ext > MAX_EXT) ? MAX_W : bus.ld_dat_i;
    end else if (bus.en_i) begin
      if (bus.dir_i) begin
        if (dat_ext < MAX_EXT) begin
          dat_d = inc_ext[width-1:0];
          tc_d  = bus.sat_i && (inc_ext == MAX_EXT);
        end else begin
          ovf_d = 1'b1;
          if (!bus.sat_i) begin
            dat_d = '0;
            tc_d  = 1'b1;
          end
        end
      end else begin
        if (dat_q != '0) begin
          dat_d = dec_ext[width-1:0];
          tc_d  = bus.sat_i && (dec_ext == '0);
        end else begin
          ovf_d = 1'b1;
          if (!bus.sat_i) begin
            dat_d = MAX_W;
            tc_d  = 1'b1;
          end
        end
      end
    end
  end

  // State register with synchronous reset overriding all controls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.dat_o = dat_q;
  assign bus.tc_o  = tc_q;
  assign bus.ovf_o = ovf_q;

`ifdef UPDOWN_COUNTER_CAPTURE_EN
  logic [width-1:0] cap_q, cap_d;

  // Snapshot the pre-update count; only reset clears it.
  always_comb begin
    cap_d = cap_q;
    if (bus.cap_i) cap_d = dat_q;
  end

  // Capture register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cap_q <= '0;
    else       cap_q <= cap_d;
  end

  assign bus.cap_o = cap_q;
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter (width=4, maxval=9) with an expectation
// queue: each step pushes the expected post-edge outputs, then pops and
// checks them one cycle later.
module tb_updown_counter;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] dat;
    logic         tc;
    logic         ovf;
    logic [W-1:0] cap;
    string        tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cap_drv = 1'b0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  updown_counter_if #(.width(W)) bus_if ();

  updown_counter #(.width(W), .maxval(9)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

`ifdef UPDOWN_COUNTER_CAPTURE_EN
  assign bus_if.cap_i = cap_drv;
`endif

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  // One clock: drive controls, queue expectation, check after the edge.
  task automatic step(input string tag, input logic r, input logic clr, input logic ld,
                      input logic [W-1:0] ldd, input logic en, input logic dir,
                      input logic sat, input logic cap,
                      input logic [W-1:0] e_dat, input logic e_tc, input logic e_ovf,
                      input logic [W-1:0] e_cap);
    exp_t e;
    rst             = r;
    bus_if.clr_i    = clr;
    bus_if.ld_i     = ld;
    bus_if.ld_dat_i = ldd;
    bus_if.en_i     = en;
    bus_if.dir_i    = dir;
    bus_if.sat_i    = sat;
    cap_drv         = cap;
    sb.push_back('{e_dat, e_tc, e_ovf, e_cap, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".dat"}, bus_if.dat_o, e.dat);
    chk({e.tag, ".tc"},  {{(W-1){1'b0}}, bus_if.tc_o},  {{(W-1){1'b0}}, e.tc});
    chk({e.tag, ".ovf"}, {{(W-1){1'b0}}, bus_if.ovf_o}, {{(W-1){1'b0}}, e.ovf});
`ifdef UPDOWN_COUNTER_CAPTURE_EN
    chk({e.tag, ".cap"}, bus_if.cap_o, e.cap);
`endif
  endtask

  initial begin
    bus_if.clr_i = 0; bus_if.ld_i = 0; bus_if.ld_dat_i = 0;
    bus_if.en_i = 0;  bus_if.dir_i = 0; bus_if.sat_i = 0;
    @(posedge clk); #1;

    //            tag        r clr ld ldd en dir sat cap   dat tc ovf cap
    // reset held two cycles with counting requested
    step("rst0",   1, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0);
    step("rst1",   1, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0);

    // up, wrap mode, 12 steps: 1..9, 0, 1, 2
    for (int i = 1; i <= 12; i++) begin
      logic [W-1:0] d;
      d = W'(i % 10);
      step($sformatf("up%0d", i), 0, 0, 0, 0, 1, 1, 0, 0, d, i == 10, i >= 10, 0);
    end

    // clear, then over-range load clamps to maxval
    step("clr",    0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    step("ld12",   0, 0, 1, 12, 0, 0, 0, 0,  9, 0, 0, 0);
    // down, saturate: 8..1, 0 with tc, then hold at 0 with ovf
    for (int i = 1; i <= 11; i++) begin
      logic [W-1:0] d;
      d = (i <= 9) ? W'(9 - i) : '0;
      step($sformatf("dn%0d", i), 0, 0, 0, 0, 1, 0, 1, 0, d, i == 9, i >= 10, 0);
    end

    // clear beats load and enable
    step("ld5",    0, 0, 1, 5, 0, 0, 0, 0,   5, 0, 1, 0);
    step("clrld",  0, 1, 1, 7, 1, 1, 0, 0,   0, 0, 0, 0);
    step("ld7",    0, 0, 1, 7, 0, 0, 0, 0,   7, 0, 0, 0);
    // load boundary values never pulse tc; load has priority over enable
    step("ld9",    0, 0, 1, 9, 1, 1, 1, 0,   9, 0, 0, 0);
    step("ld15",   0, 0, 1, 15, 0, 0, 0, 0,  9, 0, 0, 0);
    step("ld0",    0, 0, 1, 0, 1, 0, 1, 0,   0, 0, 0, 0);

    // underflow wrap, then flip direction: overflow wrap
    step("dnwrap", 0, 0, 0, 0, 1, 0, 0, 0,   9, 1, 1, 0);
    step("upwrap", 0, 0, 0, 0, 1, 1, 0, 0,   0, 1, 1, 0);
    step("hold",   0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0);

    // up, saturate at maxval
    step("clr2",   0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    step("ld8",    0, 0, 1, 8, 0, 0, 0, 0,   8, 0, 0, 0);
    step("sat9",   0, 0, 0, 0, 1, 1, 1, 0,   9, 1, 0, 0);
    step("satov",  0, 0, 0, 0, 1, 1, 1, 0,   9, 0, 1, 0);
    step("satov2", 0, 0, 0, 0, 1, 1, 1, 0,   9, 0, 1, 0);
    // load keeps ovf
    step("ld6",    0, 0, 1, 6, 0, 0, 0, 0,   6, 0, 1, 0);
    // reset mid-count wins over load
    step("rstld",  1, 0, 1, 3, 1, 1, 0, 0,   0, 0, 0, 0);

    // capture: pre-update snapshot, held while cap_i low, reset-only clear
    step("ld3",    0, 0, 1, 3, 0, 0, 0, 0,   3, 0, 0, 0);
    step("cap3",   0, 0, 0, 0, 1, 1, 0, 1,   4, 0, 0, 3);
    step("caph",   0, 0, 0, 0, 1, 1, 0, 0,   5, 0, 0, 3);
    step("capclr", 0, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 5);
    step("caprst", 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
Parametrised up/down counter and the successor of the free-running clear-only counter. Adds programmable modulo, direction control, count enable, parallel load, wrap/saturate mode, a terminal-count strobe and a sticky overflow flag. Used for timing and sample-period generation in the digital audio datapath. One clock domain, synchronous reset.

Parameters:
width, 10, counter width in bits; legal range 2..32.
maxval, 1023, top count value; legal range 1..2**width-1. The count range is 0..maxval.

Ports:
clk_i  input  1  clock; all logic on posedge.
rst_i  input  1  reset; synchronous, active-high.
clr_i  input  1  synchronous clear of dat_o and ovf_o.
ld_i  input  1  parallel load strobe.
ld_dat_i  input  width  load value.
en_i  input  1  count enable.
dir_i  input  1  count direction; 1 = up, 0 = down.
sat_i  input  1  boundary mode; 1 = saturate, 0 = wrap.
dat_o  output  width  current count (registered).
tc_o  output  1  terminal-count strobe (registered).
ovf_o  output  1  sticky overflow/underflow flag (registered).

Behaviour:
- All state changes on posedge clk_i. No asynchronous paths. No combinational path from inputs to outputs.
- Reset: when rst_i=1 at a clock edge, dat_o=0, tc_o=0, ovf_o=0. Reset overrides every other input, including a reset asserted mid-count.
- Priority per cycle is rst_i > clr_i > ld_i > en_i.
- clr_i: dat_o=0, ovf_o=0, tc_o=0.
- ld_i: dat_o = min(ld_dat_i, maxval). tc_o=0. ovf_o is unchanged. A load never raises tc_o, even when the loaded value is a boundary.
- en_i=0 with no clr/ld: dat_o holds and tc_o=0.
- Counting up (en_i=1, dir_i=1):
  - If dat_o<maxval: dat_o+1. tc_o=1 only if the new value equals maxval and sat_i=1; otherwise tc_o=0.
  - If dat_o==maxval and sat_i=0: dat_o=0, tc_o=1, ovf_o set.
  - If dat_o==maxval and sat_i=1: dat_o holds at maxval, tc_o=0, ovf_o set.
- Counting down (en_i=1, dir_i=0), symmetric to counting up:
  - If dat_o>0: dat_o-1. tc_o=1 only if the new value is 0 and sat_i=1.
  - If dat_o==0 and sat_i=0: dat_o=maxval, tc_o=1, ovf_o set.
  - If dat_o==0 and sat_i=1: dat_o holds at 0, tc_o=0, ovf_o set.
- dat_o takes effect one cycle after the control inputs are sampled. tc_o is aligned with the dat_o value that caused it and is a single-cycle pulse per event.
- ovf_o stays set until rst_i or clr_i.
- dir_i and sat_i may change on any cycle; each takes effect on the next enabled step. No hidden state beyond dat_o, tc_o and ovf_o.
- Arithmetic is done in width+1 bits internally. dat_o never exceeds maxval, including when maxval=2**width-1.

Optional Feature:
UPDOWN_COUNTER_CAPTURE_EN
- Defined: adds two ports, cap_i (input, 1) and cap_o (output, width). When cap_i=1 at an edge, cap_o takes the pre-update value of dat_o from that cycle. Capture is independent of ld/en/clr. cap_o resets to 0 on rst_i only.
- Undefined: neither port exists and no capture logic is built. All other behaviour is identical.

Test Plan:
1. width=4, maxval=9, rst_i=1 for 2 cycles, then en_i=1, dir_i=1, sat_i=0 for 12 cycles -> dat_o goes 1..9, 0, 1, 2. tc_o is high only in the cycle dat_o=0. ovf_o=1 from that cycle onward.
2. maxval=9, ld_dat_i=12 with ld_i=1 -> dat_o=9 and tc_o=0. Then down-count with sat_i=1 for 11 cycles -> dat_o goes 8..0. tc_o pulses once when dat_o reaches 0. dat_o holds at 0 and ovf_o=1.
3. dat_o=5, and in the same cycle clr_i=1, ld_i=1 (ld_dat_i=7), en_i=1 -> dat_o=0, ovf_o=0. Next cycle with ld_i=1 only -> dat_o=7.
4. dat_o=0, dir_i=0, sat_i=0, en_i=1 -> dat_o=9, tc_o=1, ovf_o=1. Then toggle dir_i to 1 -> dat_o=0, tc_o=1.
5. Mid-count at dat_o=6, assert rst_i together with ld_i=1 -> dat_o=0, tc_o=0, ovf_o=0 (reset wins).
6. With UPDOWN_COUNTER_CAPTURE_EN defined, up-counting, dat_o=3, cap_i=1 -> next cycle cap_o=3 and dat_o=4.
